// File: rtl/locked_adder_corruption_monitor_pkg.sv
// -----------------------------------------------------------------------------
// lock_mon_pkg
// Shared definitions for the locked-adder corruption monitor:
//   - monitor state encoding (also exported on the debug state port)
//   - default widths for operands, counters and the Hamming accumulator
//   - RES_W: width of the adder result (operand width + carry)
//   - HD_VEC_W: width of a single-vector Hamming distance (0..17 fits in 5)
// -----------------------------------------------------------------------------
package lock_mon_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int HD_W_DEF  = 32;
    localparam int RES_W     = WIDTH_DEF + 1;
    localparam int HD_VEC_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lock_mon_state_e;

endpackage

// File: rtl/locked_adder_corruption_monitor_if.sv
// -----------------------------------------------------------------------------
// locked_adder_corruption_monitor_if
// Vector stream into the monitor: one operand pair plus the locked adder's
// result per beat.
//
// Handshake: a beat transfers on a rising clock edge where valid_i and
// ready_o are both 1. valid_i while ready_o is 0 is simply dropped; the
// source is not required to hold data, and the monitor never stalls.
//
// Signals:
//   valid_i       beat present on add1_i/add2_i/locked_res_i
//   ready_o       monitor accepts a beat this cycle
//   add1_i        operand A (WIDTH bits)
//   add2_i        operand B (WIDTH bits)
//   locked_res_i  locked adder result (WIDTH+1 bits)
// Modports: master = vector source, slave = monitor.
// -----------------------------------------------------------------------------
interface locked_adder_corruption_monitor_if #(
    parameter int WIDTH = lock_mon_pkg::WIDTH_DEF
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic [WIDTH:0]   locked_res_i;

    modport master (
        output valid_i,
        output add1_i,
        output add2_i,
        output locked_res_i,
        input  ready_o
    );

    modport slave (
        input  valid_i,
        input  add1_i,
        input  add2_i,
        input  locked_res_i,
        output ready_o
    );
endinterface

// File: rtl/locked_adder_corruption_monitor_hd_popcount.sv
// -----------------------------------------------------------------------------
// hd_popcount
// Combinational population count of a result-difference vector; the count is
// the per-vector Hamming distance between golden and locked results.
// Ports:
//   vec_i  in   IN_W   difference vector (golden ^ locked)
//   cnt_o  out  OUT_W  number of set bits
// -----------------------------------------------------------------------------
module hd_popcount
    import lock_mon_pkg::*;
#(
    parameter int IN_W  = RES_W,
    parameter int OUT_W = HD_VEC_W
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [OUT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            cnt_o = cnt_o + OUT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/locked_adder_corruption_monitor.sv
// -----------------------------------------------------------------------------
// locked_adder_corruption_monitor
// Sits downstream of a key-locked ripple-carry adder. For each accepted
// operand pair it recomputes the golden (WIDTH+1)-bit sum, XORs it with the
// locked result and popcounts the difference. Over a start-triggered run of
// num_vec_i vectors it accumulates the number of corrupted vectors and the
// total output Hamming distance, quantifying corruption for one trial key.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-high reset
//   start_i     in   begin a run (sampled only in IDLE)
//   num_vec_i   in   vectors in the run, latched on start
//   vec_if      --   slave side of the vector stream (valid/ready + data)
//   busy_o      out  run in progress (RUN or DRAIN)
//   done_o      out  one-cycle pulse when results are final
//   mism_cnt_o  out  vectors with any wrong result bit (saturating)
//   hd_sum_o    out  sum of per-vector Hamming distances (saturating)
//   max_hd_o    out  largest per-vector Hamming distance of the run
//   state_o     out  current FSM state (debug visibility)
//
// Build option: define MAX_HD_TRACK_EN to track max_hd_o; otherwise it is
// tied to zero and no compare logic exists.
//
// Timing: a vector sampled at edge t lands in S1 at t, S2 at t+1 and the
// accumulators at t+2, i.e. it is visible after the third edge counted from
// the cycle it is presented in.
// -----------------------------------------------------------------------------
module locked_adder_corruption_monitor
    import lock_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int HD_W  = HD_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     num_vec_i,
    locked_adder_corruption_monitor_if.slave vec_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     mism_cnt_o,
    output logic [HD_W-1:0]      hd_sum_o,
    output logic [HD_VEC_W-1:0]  max_hd_o,
    output lock_mon_state_e      state_o
);

    localparam int RW = WIDTH + 1;

    lock_mon_state_e     state;
    logic [CNT_W-1:0]    remaining;
    logic                ready_q;
    logic                accept;
    logic                start_take;

    logic [RW-1:0]       golden;
    logic [RW-1:0]       diff;
    logic [RW-1:0]       s1_diff;
    logic                s1_valid;
    logic [HD_VEC_W-1:0] s1_pop;
    logic [HD_VEC_W-1:0] s2_hd;
    logic                s2_valid;
    logic [HD_W:0]       hd_sum_wide;

    assign vec_if.ready_o = ready_q;
    assign state_o        = state;
    assign accept         = vec_if.valid_i & ready_q;
    assign start_take     = (state == IDLE) & start_i;

    // Golden sum keeps the carry so a dropped carry counts as a corrupted bit.
    assign golden = {1'b0, vec_if.add1_i} + {1'b0, vec_if.add2_i};
    assign diff   = golden ^ vec_if.locked_res_i;

    hd_popcount #(
        .IN_W  (RW),
        .OUT_W (HD_VEC_W)
    ) u_hd_popcount (
        .vec_i (s1_diff),
        .cnt_o (s1_pop)
    );

    // One extra bit catches accumulator overflow for saturation.
    assign hd_sum_wide = {1'b0, hd_sum_o} + (HD_W + 1)'(s2_hd);

    // ---------------- pipeline: S1 diff, S2 Hamming distance -----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_diff  <= '0;
            s1_valid <= 1'b0;
            s2_hd    <= '0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= diff;
            end
            s2_valid <= s1_valid;
            s2_hd    <= s1_valid ? s1_pop : '0;
        end
    end

    // ---------------- run control FSM and accumulators -----------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            remaining  <= '0;
            ready_q    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            mism_cnt_o <= '0;
            hd_sum_o   <= '0;
        end else begin
            done_o <= 1'b0;

            // The pipeline is always empty in IDLE, so accumulation never
            // collides with the start-time clear below.
            if (s2_valid) begin
                if (s2_hd != '0 && mism_cnt_o != '1) begin
                    mism_cnt_o <= mism_cnt_o + CNT_W'(1);
                end
                hd_sum_o <= hd_sum_wide[HD_W] ? '1 : hd_sum_wide[HD_W-1:0];
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        mism_cnt_o <= '0;
                        hd_sum_o   <= '0;
                        remaining  <= num_vec_i;
                        if (num_vec_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                            busy_o  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state   <= DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------- optional per-run maximum Hamming distance -------------
`ifdef MAX_HD_TRACK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_hd_o <= '0;
        end else if (start_take) begin
            max_hd_o <= '0;
        end else if (s2_valid && (s2_hd > max_hd_o)) begin
            max_hd_o <= s2_hd;
        end
    end
`else
    assign max_hd_o = '0;
`endif

endmodule
